// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant and shared-bus signals between two masters, the slave and bus_arbiter
interface bus_arbiter_if #(
  parameter int dwidth = 32,
  parameter int cwidth = 8
);
  logic [1:0]        req;
  logic [dwidth-1:0] m0_data_out;
  logic [cwidth-1:0] m0_ctrl_out;
  logic [dwidth-1:0] m1_data_out;
  logic [cwidth-1:0] m1_ctrl_out;
  logic              slave_wait;
  logic [1:0]        ack;
  logic [dwidth-1:0] bus_data;
  logic [cwidth-1:0] bus_ctrl;
  logic              busy;
  logic              err;
  modport master (
    output req, m0_data_out, m0_ctrl_out, m1_data_out, m1_ctrl_out, slave_wait,
    input  ack, bus_data, bus_ctrl, busy, err
  );
  modport slave (
    input  req, m0_data_out, m0_ctrl_out, m1_data_out, m1_ctrl_out, slave_wait,
    output ack, bus_data, bus_ctrl, busy, err
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter (IDLE/ADDR/DATA) with burst beat count and slave-wait timeout; ports clk, reset, bus (req/m*_out/slave_wait in, ack/bus_data/bus_ctrl/busy/err out)
module bus_arbiter #(
  parameter int dwidth  = 32,
  parameter int cwidth  = 8,
  parameter int timeout = 16
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);
  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_addr = 2'd1;
  localparam logic [1:0] s_data = 2'd2;
  localparam int ww = $clog2(timeout + 1);
  logic [1:0]    r_state;
  logic [1:0]    r_ack;
  logic          r_busy;
  logic          r_err;
  logic          r_last;
  logic [3:0]    r_beats;
  logic [ww-1:0] r_wait;
  logic              w_win;
  logic              w_own_req;
  logic [cwidth-1:0] w_own_ctrl;
  logic [3:0]        w_beats;
  logic              w_tmo;
  logic              w_end;
  assign w_win      = &bus.req ? ~r_last : bus.req[1];
  assign w_own_req  = bus.req[r_last];
  assign w_own_ctrl = r_last ? bus.m1_ctrl_out : bus.m0_ctrl_out;
  assign w_beats    = {1'b0, w_own_ctrl[4:2]} + 4'd1;
  assign w_tmo      = bus.slave_wait && r_wait == ww'(timeout - 1);
  assign w_end      = !w_own_req || w_tmo || (!bus.slave_wait && r_beats == 4'd1);
  assign bus.ack      = r_ack;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.bus_data = r_ack[0] ? bus.m0_data_out : r_ack[1] ? bus.m1_data_out : '0;
  assign bus.bus_ctrl = r_ack[0] ? bus.m0_ctrl_out : r_ack[1] ? bus.m1_ctrl_out : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= s_idle;
      r_ack   <= 2'b00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= '0;
      r_wait  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        s_idle: if (|bus.req) begin
          r_state <= s_addr;
          r_busy  <= 1'b1;
          r_ack   <= w_win ? 2'b10 : 2'b01;
          r_last  <= w_win;
          r_wait  <= '0;
        end
        s_addr: if (!w_own_req) begin
          r_state <= s_idle;
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
        end else begin
          r_state <= s_data;
          r_beats <= w_beats;
        end
        s_data: if (w_end) begin
          r_state <= s_idle;
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
          r_wait  <= '0;
          r_err   <= w_own_req && w_tmo;
        end else if (bus.slave_wait) begin
          r_wait <= r_wait + 1'b1;
        end else begin
          r_wait  <= '0;
          r_beats <= r_beats - 4'd1;
        end
        default: begin
          r_state <= s_idle;
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
